// File: rtl/gshare_index_unit.sv
// gshare PHT index generator with an in-order prediction queue and history repair on mispredict.
// Prediction latency 2 cycles (issue, capture); resolution 1 cycle; resolution wins over a request; requests stall when the queue is full.
module gshare_index_unit #(
    parameter int DEPTH    = 4,
    parameter int HIST_LEN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [7:0]               req_pc,
    output logic                     req_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_ready,
    output logic [7:0]               pht_addr,
    output logic                     pht_request,
    output logic                     pht_result,
    output logic                     pht_taken,
    input  logic                     pht_prediction,
    output logic                     pred_valid,
    output logic                     pred_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   inflight
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, CAPT} state_t;

    state_t              state;
    logic [7:0]          cap_idx;
    logic [HIST_LEN-1:0] spec_ghr;
    logic [HIST_LEN-1:0] arch_ghr;
    logic [HIST_LEN-1:0] arch_next;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [7:0]          q_idx  [DEPTH];
    logic                q_pred [DEPTH];

    logic       res_fire;
    logic       req_fire;
    logic       mispred_now;
    logic [7:0] hash_idx;

    always_comb begin
        res_ready   = (state == IDLE) && (inflight != '0);
        res_fire    = res_valid && res_ready;
        req_ready   = (state == IDLE) && (inflight < CW'(DEPTH)) && !res_fire;
        req_fire    = req_valid && req_ready;
        hash_idx    = req_pc ^ spec_ghr[7:0];
        mispred_now = res_fire && (res_taken != q_pred[rd_ptr]);
        arch_next   = {arch_ghr[HIST_LEN-2:0], res_taken};

        pht_addr    = '0;
        pht_request = 1'b0;
        pht_result  = 1'b0;
        pht_taken   = 1'b0;
        if (res_fire) begin
            pht_addr   = q_idx[rd_ptr];
            pht_result = 1'b1;
            pht_taken  = res_taken;
        end else if (req_fire) begin
            pht_addr    = hash_idx;
            pht_request = 1'b1;
        end else if (state == CAPT) begin
            pht_addr = cap_idx;
        end
    end

    // Queue storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (state == CAPT) begin
            q_idx[wr_ptr]  <= cap_idx;
            q_pred[wr_ptr] <= pht_prediction;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_idx    <= '0;
            spec_ghr   <= '0;
            arch_ghr   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            inflight   <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_fire) begin
                        arch_ghr <= arch_next;
                        if (mispred_now) begin
                            // Every younger prediction used wrong-path history: drop them all.
                            rd_ptr     <= wr_ptr;
                            inflight   <= '0;
                            spec_ghr   <= arch_next;
                            mispredict <= 1'b1;
                        end else begin
                            rd_ptr   <= rd_ptr + PW'(1);
                            inflight <= inflight - CW'(1);
                        end
                    end else if (req_fire) begin
                        cap_idx <= hash_idx;
                        state   <= CAPT;
                    end
                end
                CAPT: begin
                    wr_ptr     <= wr_ptr + PW'(1);
                    inflight   <= inflight + CW'(1);
                    spec_ghr   <= {spec_ghr[HIST_LEN-2:0], pht_prediction};
                    pred_valid <= 1'b1;
                    pred_taken <= pht_prediction;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
